// File: rtl/riscv_defines.sv
// Shared RV32M decode constants, divider state encodings and small helpers.
package riscv_defines;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] FUNC3_DIV  = 3'b100;
    localparam logic [2:0] FUNC3_DIVU = 3'b101;
    localparam logic [2:0] FUNC3_REM  = 3'b110;
    localparam logic [2:0] FUNC3_REMU = 3'b111;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    // Signed variants are DIV and REM.
    function automatic logic func3_is_signed(input logic [2:0] f);
        logic s;
        case (f)
            FUNC3_DIV, FUNC3_REM: s = 1'b1;
            default:              s = 1'b0;
        endcase
        return s;
    endfunction

    // Remainder variants are REM and REMU.
    function automatic logic func3_is_rem(input logic [2:0] f);
        logic r;
        case (f)
            FUNC3_REM, FUNC3_REMU: r = 1'b1;
            default:               r = 1'b0;
        endcase
        return r;
    endfunction

    // Magnitude of a two's complement value when signed handling is enabled.
    function automatic logic [31:0] abs_if(input logic [31:0] v, input logic en);
        logic [31:0] a;
        if (en && v[31]) begin
            a = 32'd0 - v;
        end else begin
            a = v;
        end
        return a;
    endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step. The quotient bit is shifted into the
// low end of the dividend register, so after all steps dvd holds the quotient.
module div_step (
    input  logic [31:0] rem,
    input  logic [31:0] dvd,
    input  logic [31:0] divisor,
    output logic [31:0] rem_next,
    output logic [31:0] dvd_next,
    output logic        q_bit
);

    logic [32:0] shifted_s;
    logic [32:0] diff_s;

    // Shift, trial-subtract on 33 bits, restore when the difference is negative.
    always_comb begin
        shifted_s = {rem, dvd[31]};
        diff_s    = shifted_s - {1'b0, divisor};
        if (!diff_s[32]) begin
            q_bit    = 1'b1;
            rem_next = diff_s[31:0];
        end else begin
            q_bit    = 1'b0;
            rem_next = shifted_s[31:0];
        end
        dvd_next = {dvd[30:0], q_bit};
    end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU/REM/REMU sequencer for the execute stage. Stalls the
// front of the pipe while a restoring divider iterates, then presents the
// result for one cycle alongside a done pulse.
module div_sequencer
    import riscv_defines::*;
#(
    parameter int ITERATIONS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  func3,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  logic        flush,
    output logic        stall,
    output logic        done,
    output logic [31:0] result
);

    localparam int CNT_W = $clog2(ITERATIONS);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(ITERATIONS - 1);

    div_state_t        state_r;
    logic [2:0]        func3_r;
    logic              neg_q_r;
    logic              neg_r_r;
    logic [31:0]       rem_r;
    logic [31:0]       dvd_r;
    logic [31:0]       divisor_r;
    logic [CNT_W-1:0]  count_r;
    logic [31:0]       result_r;

    logic              start_signed_s;
    logic              start_rem_s;
    logic [31:0]       abs_op1_s;
    logic [31:0]       abs_op2_s;
    logic              special_s;
    logic [31:0]       special_val_s;

    logic [31:0]       rem_next_s;
    logic [31:0]       dvd_next_s;
    logic              q_bit_s;
    logic [31:0]       final_val_s;

    div_step u_step (
        .rem      (rem_r),
        .dvd      (dvd_r),
        .divisor  (divisor_r),
        .rem_next (rem_next_s),
        .dvd_next (dvd_next_s),
        .q_bit    (q_bit_s)
    );

    // Decode the incoming operation and take operand magnitudes for signed ops.
    always_comb begin
        start_signed_s = func3_is_signed(func3);
        start_rem_s    = func3_is_rem(func3);
        abs_op1_s      = abs_if(op1, start_signed_s);
        abs_op2_s      = abs_if(op2, start_signed_s);
    end

    // Divide-by-zero and signed overflow are answered without iterating.
    always_comb begin
        special_s     = 1'b0;
        special_val_s = 32'd0;
        if (op2 == 32'd0) begin
            special_s     = 1'b1;
            special_val_s = start_rem_s ? op1 : 32'hFFFF_FFFF;
        end else if (start_signed_s && (op1 == 32'h8000_0000) && (op2 == 32'hFFFF_FFFF)) begin
            special_s     = 1'b1;
            special_val_s = start_rem_s ? 32'd0 : 32'h8000_0000;
        end else begin
            special_s     = 1'b0;
            special_val_s = 32'd0;
        end
    end

    // Sign-correct the outcome of the final step (quotient or remainder).
    always_comb begin
        final_val_s = 32'd0;
        if (func3_is_rem(func3_r)) begin
            final_val_s = neg_r_r ? (32'd0 - rem_next_s) : rem_next_s;
        end else begin
            final_val_s = neg_q_r ? (32'd0 - dvd_next_s) : dvd_next_s;
        end
    end

    // Sequencer FSM: operand latch, iteration, result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= DIV_IDLE;
            func3_r   <= 3'd0;
            neg_q_r   <= 1'b0;
            neg_r_r   <= 1'b0;
            rem_r     <= 32'd0;
            dvd_r     <= 32'd0;
            divisor_r <= 32'd0;
            count_r   <= '0;
            result_r  <= 32'd0;
        end else if (flush) begin
            state_r <= DIV_IDLE;
            count_r <= '0;
        end else begin
            case (state_r)
                DIV_IDLE: begin
                    if (start) begin
                        func3_r   <= func3;
                        neg_q_r   <= start_signed_s & (op1[31] ^ op2[31]);
                        neg_r_r   <= start_signed_s & op1[31];
                        dvd_r     <= abs_op1_s;
                        divisor_r <= abs_op2_s;
                        rem_r     <= 32'd0;
                        count_r   <= '0;
                        if (special_s) begin
                            result_r <= special_val_s;
                            state_r  <= DIV_DONE;
                        end else begin
                            state_r  <= DIV_RUN;
                        end
                    end else begin
                        state_r <= DIV_IDLE;
                    end
                end
                DIV_RUN: begin
                    rem_r   <= rem_next_s;
                    dvd_r   <= dvd_next_s;
                    count_r <= count_r + CNT_W'(1);
                    if (count_r == LAST_COUNT) begin
                        result_r <= final_val_s;
                        count_r  <= '0;
                        state_r  <= DIV_DONE;
                    end else begin
                        state_r  <= DIV_RUN;
                    end
                end
                DIV_DONE: begin
                    state_r <= DIV_IDLE;
                end
                default: begin
                    state_r <= DIV_IDLE;
                end
            endcase
        end
    end

    // Pipeline handshake: stall drops immediately on flush and in DONE.
    always_comb begin
        stall  = ~flush & (((state_r == DIV_IDLE) & start) | (state_r == DIV_RUN));
        done   = (state_r == DIV_DONE);
        result = result_r;
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer: each issued operation pushes its expected
// result and completion cycle; an independent monitor checks every done pulse.
module tb_div_sequencer;
    import riscv_defines::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  func3;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        flush;
    logic        stall;
    logic        done;
    logic [31:0] result;

    int cyc   = 0;
    int tests = 0;
    int fails = 0;
    logic [31:0] last_res = 32'd0;

    typedef struct {
        logic [31:0] res;
        int          cyc;
        string       name;
    } exp_t;

    exp_t sb[$];

    div_sequencer #(.ITERATIONS(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .func3  (func3),
        .op1    (op1),
        .op2    (op2),
        .flush  (flush),
        .stall  (stall),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst === 1'b0 && done === 1'b1) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: done at cycle %0d with result 0x%08h, expected no done", cyc, result);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check(e.name, result, e.res);
                check({e.name, " done_cycle"}, 32'(cyc), 32'(e.cyc));
                check({e.name, " stall_in_done"}, {31'd0, stall}, 32'd0);
            end
        end
    end

    task automatic wait_drain(input string name);
        for (int i = 0; i < 100; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
        end
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL %s timeout: %0d results outstanding, expected 0", name, sb.size());
            sb.delete();
        end
        @(posedge clk);
    endtask

    // Launch one operation for a single cycle, then scramble operands during RUN.
    task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        @(posedge clk); #1;
        start = 1'b1; func3 = f; op1 = a; op2 = b;
        sb.push_back('{exp, cyc + lat, name});
        @(negedge clk);
        check({name, " stall_at_start"}, {31'd0, stall}, 32'd1);
        @(posedge clk); #1;
        start = 1'b0; op1 = ~a; op2 = ~b;
        wait_drain(name);
        last_res = exp;
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; flush = 1'b0; func3 = 3'd0; op1 = 32'd0; op2 = 32'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset stall", {31'd0, stall}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset result", result, 32'd0);

        run_op("divu_100_7",  FUNC3_DIVU, 32'd100, 32'd7, 32'd14, 33);
        run_op("remu_100_7",  FUNC3_REMU, 32'd100, 32'd7, 32'd2, 33);
        run_op("div_m7_2",    FUNC3_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        run_op("rem_m7_2",    FUNC3_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        run_op("rem_7_m2",    FUNC3_REM,  32'd7, 32'hFFFF_FFFE, 32'd1, 33);
        run_op("div_7_m2",    FUNC3_DIV,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
        run_op("divu_5_0",    FUNC3_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("remu_5_0",    FUNC3_REMU, 32'd5, 32'd0, 32'd5, 1);
        run_op("rem_m5_0",    FUNC3_REM,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1);
        run_op("div_ovf",     FUNC3_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_ovf",     FUNC3_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
        run_op("divu_ovfpat", FUNC3_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33);
        run_op("remu_big",    FUNC3_REMU, 32'hFFFF_FFFF, 32'hC000_0000, 32'h3FFF_FFFF, 33);

        // Flush in the 10th RUN cycle: no done, stall drops at once, result kept.
        @(posedge clk); #1;
        start = 1'b1; func3 = FUNC3_DIVU; op1 = 32'd100; op2 = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        check("flush stall_same_cycle", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush stall_after", {31'd0, stall}, 32'd0);
        check("flush done_after", {31'd0, done}, 32'd0);
        check("flush result_kept", result, last_res);
        repeat (40) @(posedge clk);
        run_op("divu_9_3", FUNC3_DIVU, 32'd9, 32'd3, 32'd3, 33);

        // Reset in the middle of RUN clears every output.
        @(posedge clk); #1;
        start = 1'b1; func3 = FUNC3_DIVU; op1 = 32'd100; op2 = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst stall", {31'd0, stall}, 32'd0);
        check("rst done", {31'd0, done}, 32'd0);
        check("rst result", result, 32'd0);
        repeat (40) @(posedge clk);

        // Back-to-back with start held: second op launches in IDLE after DONE.
        @(posedge clk); #1;
        start = 1'b1; func3 = FUNC3_DIVU; op1 = 32'hFFFF_FFFF; op2 = 32'd3;
        n = cyc;
        sb.push_back('{32'h5555_5555, n + 33, "b2b_first"});
        sb.push_back('{32'd100, n + 67, "b2b_second"});
        @(posedge clk); #1;
        op1 = 32'd1000; op2 = 32'd10;
        repeat (33) @(posedge clk);
        #1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_drain("b2b");

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global bound on simulation length.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
